// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used across the core: opcode encodings and
// canonical instruction constants.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  // addi x0,x0,0 (32'h0000_0013) with the two always-one low bits dropped
  localparam logic [29:0] NOP_BITS = 30'h0000_0004;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {instr, curr_pc, inc_pc} entries. Back-pressures
// fetch when full and drops everything on a taken jump/branch.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [29:0]                in_instr,
  input  logic [XLEN-1:0]            in_curr_pc,
  input  logic [XLEN-1:0]            in_inc_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [29:0]                out_instr,
  output logic [XLEN-1:0]            out_curr_pc,
  output logic [XLEN-1:0]            out_inc_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [29:0]     instr;
    logic [XLEN-1:0] curr_pc;
    logic [XLEN-1:0] inc_pc;
  } entry_t;

  entry_t        storage [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full and empty come straight from count: no pass-through when full,
  // no bypass when empty.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; out_valid gates every read, so stale
  // contents never reach the outputs and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      storage[wr_ptr] <= '{instr: in_instr, curr_pc: in_curr_pc, inc_pc: in_inc_pc};
    end
  end

  // NOTE: defaults are assigned first so every path drives every output and
  // no latch is inferred.
  always_comb begin
    out_instr   = NOP_BITS;
    out_curr_pc = '0;
    out_inc_pc  = '0;
    if (out_valid) begin
      out_instr   = storage[rd_ptr].instr;
      out_curr_pc = storage[rd_ptr].curr_pc;
      out_inc_pc  = storage[rd_ptr].inc_pc;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Small FIFO between the instruction fetch unit and decode. Holds fetched {instr, curr_pc, inc_pc} entries to decouple fetch bus latency from decode/execute stalls. Drives back-pressure into fetch. Flushes on a taken jump/branch so no wrong-path instruction reaches decode.

Parameters:
XLEN, 32, data/address width of the PC fields
DEPTH, 4, entry count; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  taken jump/branch from execute (same signal as fetch's je); discard all entries
in_valid  input  1  fetch presents a valid instruction this cycle
in_ready  output  1  queue accepts a push this cycle; fetch stalls when low
in_instr  input  30  instruction bits [31:2], already decompressed
in_curr_pc  input  XLEN  PC of the instruction
in_inc_pc  input  XLEN  PC of the sequential successor
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes head this cycle
out_instr  output  30  head instruction bits [31:2]
out_curr_pc  output  XLEN  head PC
out_inc_pc  output  XLEN  head successor PC
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, on rst high, independent of clk): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out_instr=NOP_BITS, out_curr_pc=0, out_inc_pc=0. Storage contents are not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). No pass-through when full: a push is rejected while full even if a pop occurs in the same cycle. in_ready rises the cycle after the pop.
- out_valid = (count != 0). No bypass when empty: push-to-out_valid latency is 1 cycle.
- Output fields come combinationally from storage[rd_ptr] when out_valid=1. When out_valid=0, the outputs are forced to out_instr=NOP_BITS (addi x0,x0,0 -> bits[31:2]=30'h0000_0004) and both PCs to 0.
- Push writes storage[wr_ptr], then wr_ptr+1. Pop advances rd_ptr+1. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur. A simultaneous push and pop is legal whenever 0 < count < DEPTH.
- flush (synchronous, highest priority): next cycle wr_ptr=rd_ptr=0 and count=0. A push in the flush cycle is discarded. A pop in the flush cycle still counts as consumed by decode, but has no effect on the state.
- flush and push both present while empty: the entry is discarded and out_valid stays 0.
- rst asserted mid-operation: all entries are lost immediately and the outputs take their reset values in the same cycle.
- in_valid while in_ready=0 is ignored. Fetch must hold its data, so the queue does not latch it.
- No X on outputs after reset in any state.

Decomposition:
- Shared package riscv_pkg gets NOP_BITS (30'h0000_0004, the encoding of addi x0,x0,0 with the low two bits dropped). The opcode enum is already there.
- The entry struct {instr, curr_pc, inc_pc} is local to the module because it depends on XLEN.
- No sub-module: the pointer/count logic is too small to justify one, and storage is an inline unpacked array.

Test Plan:
- Reset then idle: rst pulse with in_valid=0 -> out_valid=0, in_ready=1, count=0, out_instr=30'h4, PCs 0.
- Fill and drain, DEPTH=4, out_ready=0: push PCs 0x0,0x4,0x8,0xC -> in_ready=0 after 4th push, count=4. Fifth push ignored. Then out_ready=1 -> outputs 0x0,0x4,0x8,0xC in order over 4 cycles, then out_valid=0.
- Wrap-around: 10 pushes with continuous pops, out_ready=1, in_valid=1 -> count stays 1, PCs emerge 0x0..0x24 in order, no loss or duplication across pointer wrap.
- Flush: queue holds 3 entries, assert flush together with a push of PC 0x100 -> next cycle count=0, out_valid=0. A subsequent push of 0x200 appears 1 cycle later as the head.
- Full with simultaneous pop: count=4, out_ready=1, in_valid=1 -> pop occurs, push rejected (count=3). Next cycle in_ready=1 and the push is accepted (count stays 3).
- Async reset mid-stream: rst asserted between clock edges with count=2 -> out_valid falls before the next posedge and count=0. After release, the first push is delivered correctly.
